uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  UART receiver. Counterpart of the team's UART_TX transmitter. Samples an asynchronous serial line and
//  recovers frames of 1 start bit (0), WIDTH data bits LSB first, and 1 stop bit (1). Presents each good
//  word on a parallel port with a valid/ack handshake. Flags framing errors and overruns.
//  Sits between the board RX pin and the consumer logic: command decoder, FIFO, or display.
// PARAMETERS
//  WIDTH         8    data bits per frame (>=1)
//  CLKS_PER_BIT  16   clk cycles per bit period (>=2); sets the baud rate relative to clk
// PORTS
//  clk       in   1      system clock; all logic on posedge
//  reset     in   1      reset is asynchronous and active-low
//  serialIn  in   1      raw RX line; idles high; asynchronous to clk
//  dataOut   out  WIDTH  last good received word; held stable while valid=1
//  valid     out  1      dataOut holds an unacknowledged word
//  ack       in   1      consumer takes the word; meaningful only while valid=1
//  frameErr  out  1      one-cycle pulse: the stop bit sampled 0
//  overrun   out  1      sticky: a new word replaced an unacknowledged word; cleared by ack
// BEHAVIOUR
//  Reset (reset=0, immediate): state=IDLE, both synchroniser FFs=1, dataOut=0, valid=0, frameErr=0, overrun=0.
//  Sync: serialIn passes through 2 FFs (rxs). Sampling uses only rxs, so input latency is 2 clk.
//  Bit counter cnt: width $clog2(CLKS_PER_BIT). Bit index idx: width $clog2(WIDTH+1).
//  FSM:
//   IDLE  : rxs==0 -> START, cnt=0.
//   START : cnt counts up. At cnt==CLKS_PER_BIT/2-1 (mid start bit), sample rxs:
//           1 -> IDLE (glitch rejected, no flags)
//           0 -> DATA, cnt=0, idx=0
//   DATA  : At cnt==CLKS_PER_BIT-1, sample rxs into shift[idx] (LSB first), cnt=0, idx++.
//           After WIDTH samples -> STOP.
//   STOP  : At cnt==CLKS_PER_BIT-1, sample rxs:
//           1 -> load dataOut=shift, valid=1 (next cycle), then IDLE
//           0 -> frameErr=1 for one cycle, word discarded, -> BREAK
//   BREAK : wait until rxs==1, then IDLE. A held-low line (break) never re-triggers START.
//  All samples are mid-bit. Each state after START counts a full CLKS_PER_BIT from the mid-start sample.
//  Latency: valid rises 2 + CLKS_PER_BIT/2 + (WIDTH+1)*CLKS_PER_BIT + 1 clk after the start-bit falling
//   edge at serialIn (+/-1 from sync alignment).
//  Handshake:
//   - ack while valid=1 -> valid=0 next cycle, overrun=0.
//   - ack while valid=0 is ignored.
//  Overrun: a good word arrives while valid=1 and ack=0 -> dataOut overwritten, valid stays 1, overrun=1.
//  Same-cycle ack + good-word load -> dataOut=new word, valid=1, overrun=0 (load wins over clear; no overrun).
//  Reset mid-frame: abort immediately, all outputs to reset values, no partial word delivered.
//  Frame reception continues regardless of the valid/ack state; the receiver never stalls.
// STRUCTURE
//  uart_pkg (shared with future UART blocks):
//   - typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t
//   - localparams UART_DEF_WIDTH=8, UART_DEF_CLKS_PER_BIT=16
//  Sub-module bit_sync: 2-FF synchroniser with async active-low reset to 1, reusable for other pins.
//  Remainder (FSM, counters, shift register, handshake) stays in uart_rx. Target is about 150-250 RTL lines.
// TESTING (bench WIDTH=8, CLKS_PER_BIT=4, bit-accurate serial driver task)
//  1. Frame 0x8A with good stop bit, ack tied 0 -> dataOut=0x8A, valid=1, frameErr=0, overrun=0.
//     Then ack for 1 cycle -> valid=0.
//  2. Drive serialIn low for 1 clk, then high -> FSM returns to IDLE, valid/frameErr stay 0.
//     Next frame 0x3C is received correctly.
//  3. Frame 0xF0 with stop bit=0 -> frameErr high exactly 1 cycle, valid stays 0.
//     Hold line low 20 clk -> no new START. Release, send 0x11 -> dataOut=0x11, valid=1.
//  4. Back-to-back frames 0x55 then 0xA3, no ack -> dataOut=0xA3, valid=1, overrun=1.
//     ack -> valid=0, overrun=0.
//  5. Frame 0x55, then ack asserted in the exact cycle frame 0xC7 loads -> dataOut=0xC7, valid=1, overrun=0.
//  6. Assert reset mid-DATA of frame 0xFF -> outputs at reset values within the same cycle, no valid.
//     After release, frame 0x42 -> dataOut=0x42, valid=1.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and defaults for the UART blocks.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    localparam int UART_DEF_WIDTH        = 8;
    localparam int UART_DEF_CLKS_PER_BIT = 16;

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
// Module  : bit_sync
// Brief   : Two-flop synchroniser for an asynchronous pin; both flops reset to 1.
// Revision: 1.0 - initial release
// ============================================================================
module bit_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Brief   : UART receiver (start, WIDTH data bits LSB first, stop) with
//           valid/ack output handshake, framing-error pulse and sticky overrun.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int WIDTH        = UART_DEF_WIDTH,
    parameter int CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serialIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             valid,
    input  logic             ack,
    output logic             frameErr,
    output logic             overrun
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] c_CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(WIDTH - 1);

    uart_rx_state_t   r_state;
    uart_rx_state_t   w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             r_frame_err;
    logic             w_rxs;
    logic             w_cnt_clr;
    logic             w_bit_sample;
    logic             w_stop_good;
    logic             w_stop_bad;

    bit_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (serialIn),
        .o_q   (w_rxs)
    );

    // Bits enter at the MSB and shift down, so the first (LSB) bit lands in bit 0.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign w_shift_next = w_rxs;
        end else begin : g_shift_wn
            assign w_shift_next = {w_rxs, r_shift[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_bit_sample = 1'b0;
        w_stop_good  = 1'b0;
        w_stop_bad   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxs) begin
                    w_state_next = START;
                    w_cnt_clr    = 1'b1;
                end
            end
            START: begin
                if (r_cnt == c_CNT_MID) begin
                    w_cnt_clr    = 1'b1;
                    w_state_next = w_rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_clr    = 1'b1;
                    w_bit_sample = 1'b1;
                    if (r_idx == c_IDX_LAST) begin
                        w_state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_clr = 1'b1;
                    if (w_rxs) begin
                        w_stop_good  = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_stop_bad   = 1'b1;
                        w_state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (w_rxs) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);

            if (r_state != DATA) begin
                r_idx <= '0;
            end else if (w_bit_sample) begin
                r_idx <= r_idx + IDX_W'(1);
            end

            if (w_bit_sample) begin
                r_shift <= w_shift_next;
            end

            r_frame_err <= w_stop_bad;

            // A load beats a simultaneous ack: the new word stays valid and no overrun is flagged.
            if (w_stop_good) begin
                r_data    <= r_shift;
                r_valid   <= 1'b1;
                r_overrun <= r_valid & ~ack;
            end else if (ack && r_valid) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign dataOut  = r_data;
    assign valid    = r_valid;
    assign overrun  = r_overrun;
    assign frameErr = r_frame_err;

endmodule
`default_nettype wire
